mc_controller: RTL and testbench

- Multi-cycle control FSM that sequences a MIPS datapath built from the team's existing units (instMem/dataMem, regFile, alu, sign-extend, shift, PC register, muxes).
- Decodes opcode/funct from the instruction register and drives per-cycle enables and mux selects.
- Keeps a sticky illegal-instruction flag and a retired-instruction counter.
- Replaces the combinational single-cycle decoder when the datapath moves to a shared memory port and an internal IR/ALUOut register.

---
 rtl/mc_controller.sv | 215 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for the MIPS datapath.
// Decodes opcode/funct from the IR. Drives the per-cycle enables and mux
// selects for a datapath with a shared memory port and an IR/ALUOut register.
// Also keeps a sticky illegal-instruction flag and a retired-instruction counter.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cbit, alucbit     opcode IR[31:26], funct IR[5:0]
//   zero              ALU zero flag (used in BRANCH)
//   pcWrite..pcSrc    datapath control outputs (combinational from state)
//   instr_done        high in each instruction's final state
//   illegal           sticky unknown opcode/funct flag, cleared by rst
//   instr_count       retired instructions, wraps modulo 2^CNT_W
//   dbg_state         current FSM state encoding, for observation only
//
// While rst is high, every output reads 0, including the registered ones.
// The datapath never sees a stale flag or count during reset.
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       cbit,
  input  logic [5:0]       alucbit,
  input  logic             zero,
  output logic             pcWrite,
  output logic             irWrite,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regWrite,
  output logic             regDst,
  output logic             regJal,
  output logic             dataJal,
  output logic             alusrcA,
  output logic [1:0]       alusrcB,
  output logic [2:0]       aluOp,
  output logic [1:0]       pcSrc,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXE  = 4'd6,  S_RTWB   = 4'd7,
    S_IEXE   = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t           state, state_nxt;
  logic             illegal_q, illegal_set;
  logic [CNT_W-1:0] cnt_q;

  // Decode of the R-type funct field.
  // funct_ok covers every supported funct, including jr.
  logic       funct_ok;
  logic [2:0] funct_op;
  always_comb begin
    funct_ok = 1'b1;
    funct_op = ALU_ADD;
    case (alucbit)
      6'h20:   funct_op = ALU_ADD;
      6'h22:   funct_op = ALU_SUB;
      6'h24:   funct_op = ALU_AND;
      6'h25:   funct_op = ALU_OR;
      6'h2A:   funct_op = ALU_SLT;
      6'h08:   funct_op = ALU_ADD;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state <= state_nxt;
      if (illegal_set) illegal_q <= 1'b1;
      if (instr_done)  cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt   = S_FETCH;
    illegal_set = 1'b0;
    pcWrite     = 1'b0;
    irWrite     = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    regWrite    = 1'b0;
    regDst      = 1'b0;
    regJal      = 1'b0;
    dataJal     = 1'b0;
    alusrcA     = 1'b0;
    alusrcB     = 2'b00;
    aluOp       = ALU_ADD;
    pcSrc       = 2'b00;
    instr_done  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          memread   = 1'b1;
          irWrite   = 1'b1;
          alusrcB   = 2'b01;
          pcWrite   = 1'b1;
          state_nxt = S_DECODE;
        end
        S_DECODE: begin
          // Branch target is computed speculatively into ALUOut.
          alusrcB = 2'b11;
          case (cbit)
            6'h23, 6'h2B: state_nxt = S_MEMADR;
            6'h00: begin
              if (!funct_ok)            illegal_set = 1'b1;
              else if (alucbit == 6'h08) state_nxt = S_JR;
              else                       state_nxt = S_RTEXE;
            end
            6'h04, 6'h05: state_nxt = S_BRANCH;
            6'h08, 6'h0A: state_nxt = S_IEXE;
            6'h02:        state_nxt = S_JUMP;
            6'h03:        state_nxt = S_JAL;
            default:      illegal_set = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alusrcA   = 1'b1;
          alusrcB   = 2'b10;
          state_nxt = (cbit == 6'h2B) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          iord      = 1'b1;
          memread   = 1'b1;
          state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          regWrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          iord       = 1'b1;
          memwrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_RTEXE: begin
          alusrcA   = 1'b1;
          aluOp     = funct_op;
          state_nxt = S_RTWB;
        end
        S_RTWB: begin
          regWrite   = 1'b1;
          regDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_IEXE: begin
          alusrcA   = 1'b1;
          alusrcB   = 2'b10;
          aluOp     = (cbit == 6'h0A) ? ALU_SLT : ALU_ADD;
          state_nxt = S_IWB;
        end
        S_IWB: begin
          regWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alusrcA    = 1'b1;
          aluOp      = ALU_SUB;
          pcSrc      = 2'b01;
          // Opcode bit 0 distinguishes bne (0x05) from beq (0x04).
          pcWrite    = cbit[0] ? ~zero : zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pcSrc      = 2'b10;
          pcWrite    = 1'b1;
          instr_done = 1'b1;
        end
        S_JAL: begin
          // The PC still holds PC+4 from FETCH, so $31 gets the return address
          // on the same edge that the PC takes the jump target.
          pcSrc      = 2'b10;
          pcWrite    = 1'b1;
          regWrite   = 1'b1;
          regJal     = 1'b1;
          dataJal    = 1'b1;
          instr_done = 1'b1;
        end
        S_JR: begin
          alusrcA    = 1'b1;
          pcSrc      = 2'b11;
          pcWrite    = 1'b1;
          instr_done = 1'b1;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  assign illegal     = illegal_q & ~rst;
  assign instr_count = rst ? '0 : cnt_q;
  assign dbg_state   = rst ? S_FETCH : state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed, table-driven bench for mc_controller (CNT_W=4 so wrap is reachable).
// Each table row is one clock cycle: inputs driven on the falling edge,
// outputs compared 1 ns later, before the next rising edge.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cbit, alucbit;
  logic       zero;
  logic       pcWrite, irWrite, iord, memread, memwrite, memtoreg, regWrite;
  logic       regDst, regJal, dataJal, alusrcA, instr_done, illegal;
  logic [1:0] alusrcB, pcSrc;
  logic [2:0] aluOp;
  logic [3:0] instr_count;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  mc_controller #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cbit(cbit), .alucbit(alucbit), .zero(zero),
    .pcWrite(pcWrite), .irWrite(irWrite), .iord(iord), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .regWrite(regWrite),
    .regDst(regDst), .regJal(regJal), .dataJal(dataJal), .alusrcA(alusrcA),
    .alusrcB(alusrcB), .aluOp(aluOp), .pcSrc(pcSrc), .instr_done(instr_done),
    .illegal(illegal), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, RTEXE = 4'd6, RTWB = 4'd7,
                         IEXE = 4'd8, IWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
                         JAL = 4'd12, JR = 4'd13;

  // Control vector order:
  // pcWrite irWrite iord memread memwrite memtoreg regWrite regDst regJal
  // dataJal alusrcA alusrcB[1:0] aluOp[2:0] pcSrc[1:0] instr_done
  function automatic logic [18:0] mk(input logic pcw, irw, io, mr, mw, m2r, rw, rd,
                                     rj, dj, asa, input logic [1:0] asb,
                                     input logic [2:0] op, input logic [1:0] ps,
                                     input logic dn);
    return {pcw, irw, io, mr, mw, m2r, rw, rd, rj, dj, asa, asb, op, ps, dn};
  endfunction

  function automatic logic [18:0] actual_ctrl();
    return {pcWrite, irWrite, iord, memread, memwrite, memtoreg, regWrite, regDst,
            regJal, dataJal, alusrcA, alusrcB, aluOp, pcSrc, instr_done};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  cb;
    logic [5:0]  fn;
    logic        z;
    logic [18:0] ctrl;
    logic [3:0]  st;
    logic [3:0]  cnt;
    logic        ill;
  } vec_t;

  vec_t        vecs[$];
  logic [3:0]  fill_cnt;
  logic        fill_ill;
  int          errors = 0;
  int          checks = 0;

  logic [18:0] c_zero, c_fetch, c_decode, c_memadr, c_memrd, c_memwb, c_memwr;
  logic [18:0] c_rtwb, c_iwb, c_jump, c_jal, c_jr;

  function automatic logic [18:0] c_rtexe(input logic [2:0] op);
    return mk(0,0,0,0,0,0,0,0,0,0,1,2'b00,op,2'b00,0);
  endfunction
  function automatic logic [18:0] c_iexe(input logic [2:0] op);
    return mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,op,2'b00,0);
  endfunction
  function automatic logic [18:0] c_branch(input logic pcw);
    return mk(pcw,0,0,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,1);
  endfunction

  task automatic push(input logic r, input logic [5:0] cb, input logic [5:0] fn,
                      input logic z, input logic [18:0] c, input logic [3:0] st);
    vec_t v;
    v.rst = r; v.cb = cb; v.fn = fn; v.z = z; v.ctrl = c; v.st = st;
    v.cnt = fill_cnt; v.ill = fill_ill;
    vecs.push_back(v);
  endtask

  task automatic fill_head(input logic [5:0] cb, input logic [5:0] fn, input logic z);
    push(0, cb, fn, z, c_fetch, FETCH);
    push(0, cb, fn, z, c_decode, DECODE);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] cb, input logic [5:0] fn,
                      input logic z);
    @(negedge clk);
    rst = r; cbit = cb; alucbit = fn; zero = z;
    #1;
  endtask

  initial begin
    rst = 1'b1; cbit = '0; alucbit = '0; zero = 1'b0;
    c_zero   = '0;
    c_fetch  = mk(1,1,0,1,0,0,0,0,0,0,0,2'b01,3'b000,2'b00,0);
    c_decode = mk(0,0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0);
    c_memadr = mk(0,0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0);
    c_memrd  = mk(0,0,1,1,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
    c_memwb  = mk(0,0,0,0,0,1,1,0,0,0,0,2'b00,3'b000,2'b00,1);
    c_memwr  = mk(0,0,1,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,1);
    c_rtwb   = mk(0,0,0,0,0,0,1,1,0,0,0,2'b00,3'b000,2'b00,1);
    c_iwb    = mk(0,0,0,0,0,0,1,0,0,0,0,2'b00,3'b000,2'b00,1);
    c_jump   = mk(1,0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1);
    c_jal    = mk(1,0,0,0,0,0,1,0,1,1,0,2'b00,3'b000,2'b10,1);
    c_jr     = mk(1,0,0,0,0,0,0,0,0,0,1,2'b00,3'b000,2'b11,1);
    fill_cnt = 4'd0; fill_ill = 1'b0;

    // Reset, two cycles.
    push(1, 6'h00, 6'h00, 0, c_zero, FETCH);
    push(1, 6'h00, 6'h00, 0, c_zero, FETCH);
    // lw: 5 cycles
    fill_head(6'h23, 6'h00, 0);
    push(0, 6'h23, 6'h00, 0, c_memadr, MEMADR);
    push(0, 6'h23, 6'h00, 0, c_memrd, MEMRD);
    push(0, 6'h23, 6'h00, 0, c_memwb, MEMWB);  fill_cnt = 4'd1;
    // R-type sub: 4 cycles
    fill_head(6'h00, 6'h22, 0);
    push(0, 6'h00, 6'h22, 0, c_rtexe(3'b001), RTEXE);
    push(0, 6'h00, 6'h22, 0, c_rtwb, RTWB);    fill_cnt = 4'd2;
    // sw: 4 cycles
    fill_head(6'h2B, 6'h00, 0);
    push(0, 6'h2B, 6'h00, 0, c_memadr, MEMADR);
    push(0, 6'h2B, 6'h00, 0, c_memwr, MEMWR);  fill_cnt = 4'd3;
    // beq taken / not taken, bne taken / not taken
    fill_head(6'h04, 6'h00, 1);
    push(0, 6'h04, 6'h00, 1, c_branch(1), BRANCH); fill_cnt = 4'd4;
    fill_head(6'h04, 6'h00, 0);
    push(0, 6'h04, 6'h00, 0, c_branch(0), BRANCH); fill_cnt = 4'd5;
    fill_head(6'h05, 6'h00, 0);
    push(0, 6'h05, 6'h00, 0, c_branch(1), BRANCH); fill_cnt = 4'd6;
    fill_head(6'h05, 6'h00, 1);
    push(0, 6'h05, 6'h00, 1, c_branch(0), BRANCH); fill_cnt = 4'd7;
    // jal, jr, j
    fill_head(6'h03, 6'h00, 0);
    push(0, 6'h03, 6'h00, 0, c_jal, JAL);      fill_cnt = 4'd8;
    fill_head(6'h00, 6'h08, 0);
    push(0, 6'h00, 6'h08, 0, c_jr, JR);        fill_cnt = 4'd9;
    fill_head(6'h02, 6'h00, 0);
    push(0, 6'h02, 6'h00, 0, c_jump, JUMP);    fill_cnt = 4'd10;
    // addi, slti
    fill_head(6'h08, 6'h00, 0);
    push(0, 6'h08, 6'h00, 0, c_iexe(3'b000), IEXE);
    push(0, 6'h08, 6'h00, 0, c_iwb, IWB);      fill_cnt = 4'd11;
    fill_head(6'h0A, 6'h00, 0);
    push(0, 6'h0A, 6'h00, 0, c_iexe(3'b100), IEXE);
    push(0, 6'h0A, 6'h00, 0, c_iwb, IWB);      fill_cnt = 4'd12;
    // Illegal opcode: DECODE then straight back to FETCH, not counted.
    fill_head(6'h3F, 6'h00, 0);                fill_ill = 1'b1;
    // Following add retires normally; illegal stays set.
    fill_head(6'h00, 6'h20, 0);
    push(0, 6'h00, 6'h20, 0, c_rtexe(3'b000), RTEXE);
    push(0, 6'h00, 6'h20, 0, c_rtwb, RTWB);    fill_cnt = 4'd13;
    // Illegal funct under R-type.
    fill_head(6'h00, 6'h3F, 0);
    // and, or
    fill_head(6'h00, 6'h24, 0);
    push(0, 6'h00, 6'h24, 0, c_rtexe(3'b010), RTEXE);
    push(0, 6'h00, 6'h24, 0, c_rtwb, RTWB);    fill_cnt = 4'd14;
    fill_head(6'h00, 6'h25, 0);
    push(0, 6'h00, 6'h25, 0, c_rtexe(3'b011), RTEXE);
    push(0, 6'h00, 6'h25, 0, c_rtwb, RTWB);    fill_cnt = 4'd15;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].cb, vecs[i].fn, vecs[i].z);
      check("ctrl",  i, 32'(actual_ctrl()), 32'(vecs[i].ctrl));
      check("state", i, 32'(dbg_state),     32'(vecs[i].st));
      check("count", i, 32'(instr_count),   32'(vecs[i].cnt));
      check("illegal", i, 32'(illegal),     32'(vecs[i].ill));
    end

    // Counter wrap: count is 15, one slt retires, count returns to 0.
    step(0, 6'h00, 6'h2A, 0);
    check("wrap_pre_count", 1000, 32'(instr_count), 32'd15);
    step(0, 6'h00, 6'h2A, 0);
    step(0, 6'h00, 6'h2A, 0);
    check("slt_aluop", 1001, 32'(aluOp), 32'd4);
    step(0, 6'h00, 6'h2A, 0);
    check("slt_done", 1002, 32'(instr_done), 32'd1);
    step(0, 6'h00, 6'h00, 0);
    check("wrap_count", 1003, 32'(instr_count), 32'd0);
    check("wrap_state", 1004, 32'(dbg_state), 32'(FETCH));

    // Reset during MEMRD: lw aborted, all outputs 0, clean restart.
    step(0, 6'h23, 6'h00, 0);
    step(0, 6'h23, 6'h00, 0);
    step(0, 6'h23, 6'h00, 0);
    check("pre_rst_memrd", 1010, 32'(dbg_state), 32'(MEMRD));
    step(1, 6'h23, 6'h00, 0);
    check("rst_ctrl", 1011, 32'(actual_ctrl()), 32'd0);
    check("rst_illegal", 1012, 32'(illegal), 32'd0);
    check("rst_count", 1013, 32'(instr_count), 32'd0);
    step(1, 6'h23, 6'h00, 0);
    check("rst_hold_ctrl", 1014, 32'(actual_ctrl()), 32'd0);
    step(0, 6'h23, 6'h00, 0);
    check("post_rst_state", 1015, 32'(dbg_state), 32'(FETCH));
    check("post_rst_ctrl", 1016, 32'(actual_ctrl()), 32'(c_fetch));
    check("post_rst_count", 1017, 32'(instr_count), 32'd0);
    check("post_rst_illegal", 1018, 32'(illegal), 32'd0);
    step(0, 6'h23, 6'h00, 0);
    check("post_rst_decode", 1019, 32'(dbg_state), 32'(DECODE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
